// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding memory request, a registered output
// slot for decode and a single-entry skid buffer to absorb a word that arrives under stall.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        valid
);

  typedef enum logic [1:0] {IDLE, FETCH, SKID, DRAIN} state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic [31:0] skid_data_reg, skid_data_next;
  logic [31:0] skid_pc_reg, skid_pc_next;
  logic [31:0] instruction_reg, instruction_next;
  logic [31:0] pc_reg, pc_next;
  logic        valid_reg, valid_next;

  logic [31:0] target;
  logic [31:0] seq_pc;
  logic        new_req;

  assign target = branch_target & ~32'h0000_0003;
  assign seq_pc = req_addr_reg + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      fetch_pc_reg    <= RESET_PC;
      req_addr_reg    <= RESET_PC;
      skid_data_reg   <= 32'd0;
      skid_pc_reg     <= 32'd0;
      instruction_reg <= 32'd0;
      pc_reg          <= RESET_PC;
      valid_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fetch_pc_reg    <= fetch_pc_next;
      req_addr_reg    <= req_addr_next;
      skid_data_reg   <= skid_data_next;
      skid_pc_reg     <= skid_pc_next;
      instruction_reg <= instruction_next;
      pc_reg          <= pc_next;
      valid_reg       <= valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    fetch_pc_next    = fetch_pc_reg;
    req_addr_next    = req_addr_reg;
    skid_data_next   = skid_data_reg;
    skid_pc_next     = skid_pc_reg;
    instruction_next = instruction_reg;
    pc_next          = pc_reg;
    // An unstalled slot is consumed by decode each cycle unless refilled below.
    valid_next       = valid_reg & stall;
    new_req          = 1'b0;

    case (state_reg)
      IDLE: begin
        state_next = FETCH;
        new_req    = 1'b1;
        if (PCSrc) fetch_pc_next = target;
      end
      FETCH: begin
        if (PCSrc) begin
          fetch_pc_next = target;
          if (imem_ready) new_req = 1'b1;
          else            state_next = DRAIN;
        end else if (imem_ready) begin
          fetch_pc_next = seq_pc;
          if (valid_reg && stall) begin
            skid_data_next = imem_data;
            skid_pc_next   = req_addr_reg;
            state_next     = SKID;
          end else begin
            instruction_next = imem_data;
            pc_next          = req_addr_reg;
            valid_next       = 1'b1;
            new_req          = 1'b1;
          end
        end
      end
      SKID: begin
        if (PCSrc) begin
          fetch_pc_next = target;
          state_next    = FETCH;
          new_req       = 1'b1;
        end else if (!stall) begin
          instruction_next = skid_data_reg;
          pc_next          = skid_pc_reg;
          valid_next       = 1'b1;
          state_next       = FETCH;
          new_req          = 1'b1;
        end
      end
      DRAIN: begin
        // The in-flight word belongs to the abandoned path and is dropped.
        if (PCSrc) fetch_pc_next = target;
        if (imem_ready) begin
          state_next = FETCH;
          new_req    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (PCSrc) valid_next = 1'b0;
    if (new_req) req_addr_next = fetch_pc_next;
  end

  assign imem_req    = (state_reg == FETCH) || (state_reg == DRAIN);
  assign imem_addr   = req_addr_reg;
  assign instruction = instruction_reg;
  assign pc          = pc_reg;
  assign valid       = valid_reg;

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  decode not accepting; output slot must hold.
REQ-005 PCSrc  input  1  redirect request, sampled on rising clk.
REQ-006 branch_target  input  32  redirect address; bits [1:0] ignored and treated as 0.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  word-aligned read address.
REQ-009 imem_ready  input  1  imem_data valid this cycle; closes the request.
REQ-010 imem_data  input  32  returned instruction word.
REQ-011 instruction  output  32  registered word to decode.
REQ-012 pc  output  32  address of instruction.
REQ-013 valid  output  1  instruction/pc hold a live word.

Function
REQ-014 The block SHALL keep a state machine with states IDLE, FETCH, SKID and DRAIN, plus registers fetch_pc, req_addr, skid_data and skid_pc.
REQ-015 IDLE SHALL last exactly one cycle after reset release, hold imem_req=0, and then go to FETCH.
REQ-016 In FETCH the block SHALL drive imem_req=1 and imem_addr=req_addr, and SHALL hold both stable until imem_ready.
REQ-017 Each new request SHALL load req_addr from fetch_pc.
REQ-018 On a FETCH cycle with imem_ready=1, PCSrc=0, and (valid=0 or stall=0), the block SHALL load instruction=imem_data, pc=req_addr and valid=1, then set fetch_pc=req_addr+4, remain in FETCH and issue the next request on the following cycle.
REQ-019 On a FETCH cycle with imem_ready=1, PCSrc=0, valid=1 and stall=1, the block SHALL capture imem_data and req_addr into the skid registers, set fetch_pc=req_addr+4 and go to SKID.
REQ-020 In SKID, imem_req SHALL be 0.
REQ-021 On the first SKID cycle with stall=0, the block SHALL move the skid word into the output slot with valid=1 and return to FETCH.
REQ-022 With stall=1 the block SHALL hold instruction, pc and valid unchanged, except on a redirect.
REQ-023 With stall=0 and no new word loaded, valid SHALL drop to 0 on the next edge.
REQ-024 PCSrc=1 SHALL take priority over stall and imem_ready: valid goes 0, the skid word is discarded and fetch_pc=branch_target.
REQ-025 A redirect from FETCH with no imem_ready that cycle SHALL go to DRAIN.
REQ-026 In DRAIN the block SHALL keep imem_req=1 with the old req_addr until imem_ready, discard that data, and then go to FETCH at the redirected fetch_pc.
REQ-027 A redirect in the same cycle as imem_ready SHALL discard the returned word and go to FETCH at the target directly, without DRAIN.
REQ-028 A redirect in DRAIN SHALL only update fetch_pc, and the last target received SHALL win.
REQ-029 A redirect in SKID or IDLE SHALL update fetch_pc and go to FETCH (IDLE still waits out its one cycle first).
REQ-030 PC arithmetic SHALL be 32-bit modular, so 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-031 Fetch-to-valid latency SHALL be one cycle after imem_ready, and zero-wait memory SHALL sustain one word per cycle when stall=0.
REQ-032 The block SHALL never hold more than one outstanding request or more than two live words (output slot plus skid).

Reset
REQ-033 While rst=1 the block SHALL hold state=IDLE, fetch_pc=req_addr=RESET_PC, pc=RESET_PC, instruction=0, valid=0, imem_req=0 and imem_addr=RESET_PC, with the skid registers cleared.
REQ-034 Reset asserted mid-request SHALL abandon the request immediately with no drain, and the word from that request SHALL never appear at the outputs.

Verification
REQ-035 Zero-wait memory returning addr+0x100, stall=0, after reset -> valid from cycle 3; pc = 0,4,8,...; instruction = 0x100,0x104,... every cycle.
REQ-036 Memory with 2-cycle latency -> imem_addr stable through each wait; valid pulses for 1 cycle per word; pc increments by 4 per word.
REQ-037 stall=1 for 3 cycles while a word returns -> SKID entered; outputs frozen; imem_req=0; after stall drops, the skid word appears next with pc = previous pc+4, with no loss or duplication.
REQ-038 PCSrc=1 with target 0x40 during a 3-cycle wait -> DRAIN; the stale word is not presented; next imem_addr=0x40; first valid pc=0x40.
REQ-039 PCSrc=1 with target 0x83 while stall=1 and SKID is full -> valid=0 next cycle; next fetch at 0x80; the skid word is discarded.
REQ-040 RESET_PC=32'hFFFF_FFFC with zero-wait memory -> pc sequence FFFF_FFFC, 0000_0000, 0000_0004; rst pulsed mid-wait -> outputs return to reset values asynchronously.
